// File: rtl/dwt_qmf_cell.sv
// Multi-channel single-stage DWT analysis cell: approximation and detail outputs from one
// low-pass prototype, with per-channel tap lines and 2:1 decimation phases.
module dwt_qmf_cell #(
  parameter int                         IN_WIDTH    = 12,
  parameter int                         COEFF_WIDTH = 12,
  parameter int                         OUT_WIDTH   = 12,
  parameter int                         FRA_WIDTH   = 8,
  parameter int                         N           = 4,
  parameter int                         CH          = 2,
  parameter logic [N*COEFF_WIDTH-1:0]   H_LP        = {12'h7C, 12'hD6, 12'h39, 12'hFDF},
  parameter logic                       PHASE_INIT  = 1'b0,
  parameter int                         CW          = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clear,
  input  logic                        in_valid,
  input  logic [CW-1:0]               ch_in,
  input  logic signed [IN_WIDTH-1:0]  x_in,
  output logic                        out_valid,
  output logic [CW-1:0]               ch_out,
  output logic signed [OUT_WIDTH-1:0] ya_out,
  output logic signed [OUT_WIDTH-1:0] yd_out
);

  localparam int ACC_W = IN_WIDTH + COEFF_WIDTH + $clog2(N) + 1;

  typedef logic signed [IN_WIDTH-1:0]    sample_t;
  typedef logic signed [COEFF_WIDTH-1:0] coeff_t;
  typedef logic signed [ACC_W-1:0]       acc_t;

  localparam acc_t RND     = acc_t'(1) <<< (FRA_WIDTH - 1);
  localparam acc_t OUT_MAX = (acc_t'(1) <<< (OUT_WIDTH - 1)) - acc_t'(1);
  localparam acc_t OUT_MIN = ~OUT_MAX;

  // tap_q[c][j-1] holds tap j of channel c; tap 0 is always the live x_in.
  sample_t       tap_q [CH][N-1];
  logic [CH-1:0] phase_q;

  sample_t sel_tap [N];
  logic    ch_hit;
  logic    sel_phase;
  logic    accept;
  logic    out_evt;
  acc_t    sum_a;
  acc_t    sum_d;

  function automatic coeff_t h_coeff(input int k);
    return H_LP[k*COEFF_WIDTH +: COEFF_WIDTH];
  endfunction

  function automatic logic signed [OUT_WIDTH-1:0] quantize(input acc_t s);
    acc_t                        r;
    logic signed [OUT_WIDTH-1:0] q;
    r = (s + RND) >>> FRA_WIDTH;
    if (r > OUT_MAX)      q = OUT_MAX[OUT_WIDTH-1:0];
    else if (r < OUT_MIN) q = OUT_MIN[OUT_WIDTH-1:0];
    else                  q = r[OUT_WIDTH-1:0];
    return q;
  endfunction

  // Channel selection by comparison rather than indexing keeps out-of-range ch_in harmless.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    ch_hit     = 1'b0;
    sel_phase  = 1'b0;
    sel_tap[0] = x_in;
    for (int j = 1; j < N; j++) sel_tap[j] = '0;
    for (int c = 0; c < CH; c++) begin
      if (ch_in == CW'(c)) begin
        ch_hit    = 1'b1;
        sel_phase = phase_q[c];
        for (int j = 1; j < N; j++) sel_tap[j] = tap_q[c][j-1];
      end
    end
  end

  assign accept  = in_valid & ch_hit & ~clear;
  assign out_evt = accept & sel_phase;

  // Detail branch uses g[k] = (-1)^k h[N-1-k], so tap l meets h[l] with sign (-1)^(N-1-l).
  always_comb begin
    sum_a = '0;
    sum_d = '0;
    for (int l = 0; l < N; l++) begin
      sum_a = sum_a + acc_t'(sel_tap[l]) * acc_t'(h_coeff(N - 1 - l));
      if (((N - 1 - l) % 2) != 0)
        sum_d = sum_d - acc_t'(sel_tap[l]) * acc_t'(h_coeff(l));
      else
        sum_d = sum_d + acc_t'(sel_tap[l]) * acc_t'(h_coeff(l));
    end
  end

  // NOTE: the tap lines are real filter state that must start at zero, so this small
  // storage is reset explicitly rather than left to power-up contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= {CH{PHASE_INIT}};
      for (int c = 0; c < CH; c++)
        for (int j = 0; j < N - 1; j++) tap_q[c][j] <= '0;
    end else if (clear) begin
      phase_q <= {CH{PHASE_INIT}};
      for (int c = 0; c < CH; c++)
        for (int j = 0; j < N - 1; j++) tap_q[c][j] <= '0;
    end else begin
      for (int c = 0; c < CH; c++) begin
        if (accept && (ch_in == CW'(c))) begin
          // NOTE: non-blocking assignments let the shift read every old tap in one edge.
          phase_q[c]  <= ~phase_q[c];
          tap_q[c][0] <= x_in;
          for (int j = 1; j < N - 1; j++) tap_q[c][j] <= tap_q[c][j-1];
        end
      end
    end
  end

  // Result registers hold across clear; only the strobe is forced low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      ch_out    <= '0;
      ya_out    <= '0;
      yd_out    <= '0;
    end else begin
      out_valid <= out_evt;
      if (out_evt) begin
        ch_out <= ch_in;
        ya_out <= quantize(sum_a);
        yd_out <= quantize(sum_d);
      end
    end
  end

endmodule

// File: tb/tb_dwt_qmf_cell.sv
// Bench for dwt_qmf_cell: default 4-tap/2-channel instance against a sample-history model,
// plus a 2-tap Haar single-channel instance with directed expectations.
module tb_dwt_qmf_cell;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              clear, in_valid;
  logic [0:0]        ch_in;
  logic signed [11:0] x_in;
  logic              out_valid;
  logic [0:0]        ch_out;
  logic signed [11:0] ya_out, yd_out;

  logic              h_clear, h_in_valid;
  logic [0:0]        h_ch_in;
  logic signed [11:0] h_x_in;
  logic              h_out_valid;
  logic [0:0]        h_ch_out;
  logic signed [11:0] h_ya_out, h_yd_out;

  dwt_qmf_cell dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .ch_in(ch_in), .x_in(x_in),
    .out_valid(out_valid), .ch_out(ch_out), .ya_out(ya_out), .yd_out(yd_out)
  );

  dwt_qmf_cell #(
    .N(2), .CH(1), .PHASE_INIT(1'b1), .H_LP({12'd181, 12'd181})
  ) dut_haar (
    .clk(clk), .rst_n(rst_n), .clear(h_clear), .in_valid(h_in_valid), .ch_in(h_ch_in),
    .x_in(h_x_in), .out_valid(h_out_valid), .ch_out(h_ch_out), .ya_out(h_ya_out),
    .yd_out(h_yd_out)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: full sample history per channel, outputs on every even-numbered sample.
  localparam int NT = 4;
  int h_lp [NT] = '{-33, 57, 214, 124};
  int g_hp [NT] = '{124, -214, 57, 33};
  int hist [2][$];
  int cnt  [2];
  int exp_valid, exp_ch, exp_ya, exp_yd;

  function automatic int qnt(input int s);
    int t;
    int q;
    t = s + 128;
    q = t / 256;
    if (t < 0 && (t % 256) != 0) q--;
    if (q > 2047) q = 2047;
    if (q < -2048) q = -2048;
    return q;
  endfunction

  function automatic int fir(input int c, input bit detail);
    int s;
    int x;
    s = 0;
    for (int l = 0; l < NT; l++) begin
      x = (l < hist[c].size()) ? hist[c][l] : 0;
      s += x * (detail ? g_hp[NT-1-l] : h_lp[NT-1-l]);
    end
    return s;
  endfunction

  task automatic model_clear();
    for (int c = 0; c < 2; c++) begin
      hist[c].delete();
      cnt[c] = 0;
    end
  endtask

  task automatic model_reset();
    model_clear();
    exp_valid = 0;
    exp_ch = 0;
    exp_ya = 0;
    exp_yd = 0;
  endtask

  task automatic step(input bit v, input int c, input int x, input bit clr);
    in_valid = v;
    ch_in    = 1'(c);
    x_in     = 12'(x);
    clear    = clr;
    exp_valid = 0;
    if (clr) begin
      model_clear();
    end else if (v) begin
      hist[c].push_front(x);
      if (hist[c].size() > NT) void'(hist[c].pop_back());
      cnt[c]++;
      if (cnt[c] % 2 == 0) begin
        exp_valid = 1;
        exp_ch = c;
        exp_ya = qnt(fir(c, 1'b0));
        exp_yd = qnt(fir(c, 1'b1));
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clear    = 1'b0;
    check("out_valid", out_valid, exp_valid);
    check("ch_out", ch_out, exp_ch);
    check("ya_out", ya_out, exp_ya);
    check("yd_out", yd_out, exp_yd);
  endtask

  task automatic step_h(input bit v, input int c, input int x,
                        input int ev, input int eya, input int eyd);
    h_in_valid = v;
    h_ch_in    = 1'(c);
    h_x_in     = 12'(x);
    @(posedge clk);
    #1;
    h_in_valid = 1'b0;
    check("haar_valid", h_out_valid, ev);
    check("haar_ch", h_ch_out, 0);
    check("haar_ya", h_ya_out, eya);
    check("haar_yd", h_yd_out, eyd);
  endtask

  initial begin
    clear = 1'b0; in_valid = 1'b0; ch_in = '0; x_in = '0;
    h_clear = 1'b0; h_in_valid = 1'b0; h_ch_in = '0; h_x_in = '0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_ch", ch_out, 0);
    check("rst_ya", ya_out, 0);
    check("rst_yd", yd_out, 0);
    check("rst_haar_valid", h_out_valid, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Impulse response
    step(1, 0, 256, 0);
    step(1, 0, 0, 0);
    check("imp_ya_s2", ya_out, 214);
    check("imp_yd_s2", yd_out, 57);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check("imp_ya_s4", ya_out, -33);
    check("imp_yd_s4", yd_out, 124);

    // DC gain and saturation
    step(0, 0, 0, 1);
    for (int i = 0; i < 6; i++) step(1, 0, 256, 0);
    check("dc_ya", ya_out, 362);
    check("dc_yd", yd_out, 0);
    step(0, 0, 0, 1);
    for (int i = 0; i < 6; i++) step(1, 0, 2047, 0);
    check("sat_hi_ya", ya_out, 2047);
    step(0, 0, 0, 1);
    for (int i = 0; i < 6; i++) step(1, 0, -2048, 0);
    check("sat_lo_ya", ya_out, -2048);
    check("sat_lo_yd", yd_out, 0);

    // Rounding half up
    step(0, 0, 0, 1);
    step(1, 0, 0, 0);
    step(1, 0, 2, 0);
    check("rnd_up", ya_out, 1);
    step(0, 0, 0, 1);
    step(1, 0, 0, 0);
    step(1, 0, 1, 0);
    check("rnd_down", ya_out, 0);

    // Channel isolation with back-to-back interleave
    step(0, 0, 0, 1);
    for (int i = 0; i < 8; i++) step(1, i % 2, (i % 2) ? 0 : 256, 0);
    check("iso_ch1_ya", ya_out, 0);

    // Clear wins over an output-phase sample; then a fresh start
    step(0, 0, 0, 1);
    step(1, 0, 100, 0);
    step(1, 0, 300, 1);
    check("clr_no_valid", out_valid, 0);
    step(1, 0, 256, 0);
    step(1, 0, 0, 0);
    check("clr_fresh_ya", ya_out, 214);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      int x;
      x = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4095)) - 2048
                                      : int'($urandom_range(0, 600)) - 300;
      step($urandom_range(0, 3) != 0, int'($urandom_range(0, 1)), x,
           $urandom_range(0, 31) == 0);
    end

    // Asynchronous reset mid-stream, right after an output event
    step(0, 0, 0, 1);
    step(1, 0, 300, 0);
    step(1, 0, -700, 0);
    rst_n = 1'b0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_ch", ch_out, 0);
    check("arst_ya", ya_out, 0);
    check("arst_yd", yd_out, 0);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    step(1, 0, 256, 0);
    step(1, 0, 0, 0);
    check("post_rst_ya", ya_out, 214);

    // Haar, single channel, phase starting at 1: outputs on samples 1, 3, 5
    step_h(1, 0, 256, 1, 181, -181);
    step_h(1, 1, 999, 0, 181, -181);
    step_h(1, 0, 256, 0, 181, -181);
    step_h(1, 0, 256, 1, 362, 0);
    step_h(1, 0, 256, 0, 362, 0);
    step_h(1, 0, 256, 1, 362, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
